// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-button debounce, edge pulse and auto-repeat front end for a FIFO

// One button lane: two-flop synchronizer, debounce counter, IDLE/DELAY/REPEAT pulse FSM.
module button_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic held_o,
  output logic pulse_o,
  output logic fire_o
);

  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] RD_LAST  = 20'(REPEAT_DELAY - 1);
  localparam logic [19:0] RP_LAST  = 20'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic        sync1_q, sync2_q;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        db_q, db_d;
  state_e      state_q, state_d;
  logic [19:0] rep_cnt_q, rep_cnt_d;
  logic        pulse_q, pulse_d;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_d     = db_q;
    if (sync2_q == db_q) begin
      db_cnt_d = 20'd0;
    end else if (db_cnt_q >= DB_LAST) begin
      db_d     = sync2_q;
      db_cnt_d = 20'd0;
    end else begin
      db_cnt_d = db_cnt_q + 20'd1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= 20'd0;
      db_q     <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_q     <= db_d;
    end
  end

  // Pulse FSM: first pulse on press, one after REPEAT_DELAY, then every REPEAT_PERIOD.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    pulse_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rep_cnt_d = 20'd0;
        if (db_q) begin
          state_d = ST_DELAY;
          pulse_d = 1'b1;
        end
      end
      ST_DELAY: begin
        if (!db_q) begin
          state_d   = ST_IDLE;
          rep_cnt_d = 20'd0;
        end else if (rep_cnt_q >= RD_LAST) begin
          state_d   = ST_REPEAT;
          rep_cnt_d = 20'd0;
          pulse_d   = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 20'd1;
        end
      end
      ST_REPEAT: begin
        if (!db_q) begin
          state_d   = ST_IDLE;
          rep_cnt_d = 20'd0;
        end else if (rep_cnt_q >= RP_LAST) begin
          rep_cnt_d = 20'd0;
          pulse_d   = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 20'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rep_cnt_d = 20'd0;
      end
    endcase
  end

  // FSM state, repeat counter and registered pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rep_cnt_q <= 20'd0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign held_o  = db_q;
  assign pulse_o = pulse_q;
  assign fire_o  = pulse_d;

endmodule

// Top: independent push and pop lanes plus synchronized switch data captured with each push.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_push_i,
  input  logic       btn_pop_i,
  input  logic [3:0] sw_i,
  output logic       en_in_o,
  output logic       en_out_o,
  output logic [3:0] data_out_o,
  output logic       push_held_o,
  output logic       pop_held_o
);

  logic [3:0] sw_sync1_q, sw_sync2_q;
  logic [3:0] data_q;
  logic       push_fire;
  logic       pop_fire;

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_push (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_push_i),
    .held_o (push_held_o),
    .pulse_o(en_in_o),
    .fire_o (push_fire)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_pop (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_pop_i),
    .held_o (pop_held_o),
    .pulse_o(en_out_o),
    .fire_o (pop_fire)
  );

  // Switch synchronizer, and data capture on the same edge that raises en_in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_sync1_q <= 4'd0;
      sw_sync2_q <= 4'd0;
      data_q     <= 4'd0;
    end else begin
      sw_sync1_q <= sw_i;
      sw_sync2_q <= sw_sync1_q;
      if (push_fire) begin
        data_q <= sw_sync2_q;
      end
    end
  end

  assign data_out_o = data_q;

  // The pop lane never touches the data register.
  logic unused_pop_fire;
  assign unused_pop_fire = pop_fire;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner

module tb_button_conditioner;

  logic       clk_i;
  logic       rst_ni;
  logic       btn_push_i;
  logic       btn_pop_i;
  logic [3:0] sw_i;
  logic       en_in_o;
  logic       en_out_o;
  logic [3:0] data_out_o;
  logic       push_held_o;
  logic       pop_held_o;

  int checks;
  int errors;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .btn_push_i (btn_push_i),
    .btn_pop_i  (btn_pop_i),
    .sw_i       (sw_i),
    .en_in_o    (en_in_o),
    .en_out_o   (en_out_o),
    .data_out_o (data_out_o),
    .push_held_o(push_held_o),
    .pop_held_o (pop_held_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    if (obs !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en_in"},  32'(en_in_o),     32'd0);
    chk({tag, "_en_out"}, 32'(en_out_o),    32'd0);
    chk({tag, "_data"},   32'(data_out_o),  32'd0);
    chk({tag, "_push_h"}, 32'(push_held_o), 32'd0);
    chk({tag, "_pop_h"},  32'(pop_held_o),  32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_ni     = 1'b0;
    btn_push_i = 1'b0;
    btn_pop_i  = 1'b0;
    sw_i       = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    // Clean press: pulse 7 edges after the rise, data captured, no repeat.
    sw_i       = 4'h5;
    btn_push_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("clean_en_in", 32'(en_in_o), 32'(k == 7));
      chk("clean_held",  32'(push_held_o), 32'(k >= 6));
      if (k == 7) chk("clean_data", 32'(data_out_o), 32'h5);
    end
    btn_push_i = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("clean_rel_en_in", 32'(en_in_o), 32'd0);
      chk("clean_rel_held",  32'(push_held_o), 32'(j < 6));
    end

    // Bounce: toggle every 2 cycles, then hold high.
    for (int k = 0; k < 12; k++) begin
      btn_push_i = ((k / 2) % 2) == 0;
      tick();
      chk("bounce_en_in", 32'(en_in_o), 32'd0);
      chk("bounce_held",  32'(push_held_o), 32'd0);
    end
    btn_push_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("bounce_final_en_in", 32'(en_in_o), 32'(k == 7));
    end
    btn_push_i = 1'b0;
    for (int j = 1; j <= 12; j++) tick();
    chk("bounce_settle_held", 32'(push_held_o), 32'd0);

    // Glitch: 3-cycle high never qualifies.
    btn_push_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) btn_push_i = 1'b0;
      tick();
      chk("glitch_en_in", 32'(en_in_o), 32'd0);
      chk("glitch_held",  32'(push_held_o), 32'd0);
    end

    // Auto-repeat on pop: pulses at 7,27,35,43,51,59 after the rise; data untouched.
    sw_i      = 4'hC;
    btn_pop_i = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      if (k == 61) btn_pop_i = 1'b0;
      tick();
      chk("repeat_en_out", 32'(en_out_o),
          32'(k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59));
      chk("repeat_en_in", 32'(en_in_o), 32'd0);
      chk("repeat_data",  32'(data_out_o), 32'h5);
    end
    chk("repeat_pop_held_end", 32'(pop_held_o), 32'd0);

    // Simultaneous press on both buttons.
    sw_i       = 4'h3;
    btn_push_i = 1'b1;
    btn_pop_i  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("simul_en_in",  32'(en_in_o),  32'(k == 7));
      chk("simul_en_out", 32'(en_out_o), 32'(k == 7));
      if (k == 7) chk("simul_data", 32'(data_out_o), 32'h3);
    end
    btn_push_i = 1'b0;
    btn_pop_i  = 1'b0;
    for (int j = 1; j <= 12; j++) tick();

    // Reset mid-repeat, release with push still held.
    sw_i       = 4'h9;
    btn_push_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("prerst_en_in", 32'(en_in_o), 32'(k == 7 || k == 27));
    end
    rst_ni = 1'b0;
    #1;
    chk_all_zero("rst_async");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all_zero("rst_hold");
    end
    rst_ni = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("postrst_en_in", 32'(en_in_o), 32'(k == 7 || k == 27));
      if (k < 7)  chk("postrst_data_pre", 32'(data_out_o), 32'h0);
      if (k == 7) chk("postrst_data",     32'(data_out_o), 32'h9);
    end
    btn_push_i = 1'b0;
    for (int j = 1; j <= 8; j++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 10000; consecutive stable cycles required before a debounced level changes.
- REQ-002: Parameter REPEAT_DELAY, default 500000; cycles from first pulse to first auto-repeat pulse.
- REQ-003: Parameter REPEAT_PERIOD, default 100000; cycles between subsequent auto-repeat pulses.
- REQ-004: clock  input  1  single clock, all state on rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: btn_push  input  1  raw, asynchronous, bouncing push button.
- REQ-007: btn_pop  input  1  raw, asynchronous, bouncing pop button.
- REQ-008: sw  input  4  raw, asynchronous data switches.
- REQ-009: en_in  output  1  one-cycle push pulse, to FIFO en_in.
- REQ-010: en_out  output  1  one-cycle pop pulse, to FIFO en_out.
- REQ-011: data_out  output  4  data for FIFO in, captured with each en_in pulse.
- REQ-012: push_held, pop_held  output  1 each  debounced button levels.

Function
- REQ-013: btn_push, btn_pop and sw SHALL each pass a two-flop synchronizer before any other use.
- REQ-014: Each button SHALL have its own debounce counter; the debounced level SHALL flip only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any cycle in which the input matches the debounced level SHALL clear the counter.
- REQ-015: Each button SHALL have an independent FSM with states IDLE, DELAY and REPEAT.
- REQ-016: IDLE -> DELAY on a debounced rising edge. The button's pulse SHALL be emitted in that transition and the repeat counter cleared.
- REQ-017: DELAY -> REPEAT when the debounced level has stayed high for REPEAT_DELAY cycles since the first pulse. A pulse SHALL be emitted in that transition.
- REQ-018: In REPEAT, a pulse SHALL be emitted every REPEAT_PERIOD cycles while the debounced level stays high.
- REQ-019: DELAY or REPEAT -> IDLE on a debounced falling edge. Pulses SHALL stop immediately, with no pulse in the falling cycle.
- REQ-020: en_in and en_out SHALL be registered, exactly one cycle wide, and separated by at least one low cycle. This is guaranteed by REPEAT_PERIOD >= 2.
- REQ-021: data_out SHALL load the synchronized sw value on the same edge that raises en_in, so it is valid during the en_in cycle. It SHALL hold until the next en_in pulse; en_out SHALL NOT affect it.
- REQ-022: Latency from a clean btn_push edge (held stable) to en_in high SHALL be exactly DEBOUNCE_CYCLES+3 clock edges: 2 synchronizer edges, DEBOUNCE_CYCLES debounce edges, 1 FSM/output edge. btn_pop to en_out SHALL have the same latency.
- REQ-023: Both buttons SHALL be fully independent; pulses on en_in and en_out in the same cycle are legal and SHALL NOT be suppressed.
- REQ-024: All counters SHALL be 20 bits wide. Parameters SHALL lie in 2..2^20-1; out-of-range values are unsupported.
- REQ-025: Counters SHALL saturate or clear and SHALL NOT wrap to produce spurious pulses.

Reset
- REQ-026: reset low SHALL immediately and asynchronously clear synchronizers, debounce counters, debounced levels, FSMs (to IDLE) and repeat counters.
- REQ-027: While reset is low, en_in, en_out, push_held, pop_held and data_out SHALL all be 0.
- REQ-028: After reset releases with a button still held, that press SHALL be treated as new: full DEBOUNCE_CYCLES+3 latency, then normal delay/repeat sequence.
- REQ-029: Reset asserted mid-operation SHALL abort any pending pulse; no pulse SHALL appear in the cycle of reset release.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
- REQ-030: Clean press: sw=4'h5, btn_push high for 12 cycles -> single en_in pulse 7 edges after the rise, data_out=4'h5 in that cycle, no repeat.
- REQ-031: Bounce and glitch: btn_push toggles every 2 cycles for 12 cycles, then holds high -> no pulse during toggling, one en_in pulse 7 edges after the final rise. A separate 3-cycle high glitch -> no pulse, push_held stays 0.
- REQ-032: Auto-repeat: btn_pop held 60 cycles -> en_out pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (t0 = first pulse), none after release debounces, data_out unchanged.
- REQ-033: Simultaneous: both buttons rise in the same cycle -> en_in and en_out high together in one cycle.
- REQ-034: Reset mid-repeat: reset low while btn_push is in REPEAT -> all outputs 0 at once. Release with btn_push still high -> en_in pulse 7 edges after release, next pulse 20 cycles later.
